// File: rtl/ring_mem_pkg.sv
// ring_mem_pkg: shared types for the ring memory server.
// FSM state encoding, queued request bundle and range helper.
package ring_mem_pkg;

    typedef enum logic [1:0] {
        sIdle,
        sRead,
        sResp
    } state_t;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] data;
        logic        wen;
        logic [7:0]  id;
    } req_t;

    function automatic logic word_in_range(
        input logic [31:0] address,
        input int unsigned depth
    );
        return (address >> 2) < depth;
    endfunction

endpackage

// File: rtl/ring_req_fifo.sv
// ring_req_fifo: circular request queue feeding the server FSM.
// Head is read combinationally; push and pop may share a cycle.
module ring_req_fifo
    import ring_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic push_valid,
    input  req_t push_data,
    output logic full,
    input  logic pop,
    output logic empty,
    output req_t head
);

    localparam int AW = $clog2(DEPTH);

    req_t           slots [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign head    = slots[rd_ptr];
    assign do_push = push_valid && !full;
    assign do_pop  = pop && !empty;

    // Payload storage; contents are don't-care until pushed.
    always_ff @(posedge clock) begin
        if (do_push) begin
            slots[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; reset flushes the queue.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (!do_push && do_pop) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/ring_mem_server.sv
// ring_mem_server: queued single-port word memory behind a
// valid/ready ring interface, with a preload port and counters.
module ring_mem_server
    import ring_mem_pkg::*;
#(
    parameter int DEPTH      = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_address,
    input  logic [31:0] req_data,
    input  logic        req_wen,
    input  logic [7:0]  req_id,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [7:0]  resp_id,
    output logic        resp_wen,
    output logic        resp_err,
    input  logic        init_wen,
    input  logic [7:0]  init_addr,
    input  logic [31:0] init_data,
    output logic [31:0] read_count,
    output logic [31:0] write_count
);

    localparam int          AW      = $clog2(DEPTH);
    localparam int unsigned DEPTH_U = DEPTH;

    state_t         state;
    state_t         state_d;
    req_t           push_req;
    req_t           head;
    logic           fifo_full;
    logic           fifo_empty;
    logic           pop;
    logic           head_ok;
    logic [AW-1:0]  head_idx;
    logic [AW-1:0]  init_idx;
    logic [AW-1:0]  idx_q;
    logic           resp_fire;
    logic [31:0]    mem [DEPTH];

    assign push_req = '{
        address: req_address,
        data:    req_data,
        wen:     req_wen,
        id:      req_id
    };

    assign req_ready  = !fifo_full && !reset;
    assign head_ok    = word_in_range(head.address, DEPTH_U);
    assign head_idx   = AW'(head.address >> 2);
    assign init_idx   = AW'(init_addr);
    assign resp_valid = state == sResp;
    assign resp_fire  = resp_valid && resp_ready;

    ring_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_valid (req_valid && req_ready),
        .push_data  (push_req),
        .full       (fifo_full),
        .pop        (pop),
        .empty      (fifo_empty),
        .head       (head)
    );

    // Memory writes: preload wins; a popped in-range write lands on the pop edge.
    always_ff @(posedge clock) begin
        if (init_wen) begin
            mem[init_idx] <= init_data;
        end else if (pop && head.wen && head_ok) begin
            mem[head_idx] <= head.data;
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= sIdle;
        end else begin
            state <= state_d;
        end
    end

    // Next state and pop; a preload write stalls the pop by a cycle.
    always_comb begin
        state_d = state;
        pop     = 1'b0;
        unique case (state)
            sIdle: begin
                if (!fifo_empty && !init_wen) begin
                    pop     = 1'b1;
                    state_d = (head.wen || !head_ok) ? sResp : sRead;
                end
            end
            sRead: begin
                state_d = sResp;
            end
            sResp: begin
                if (resp_ready) begin
                    state_d = sIdle;
                end
            end
            default: begin
                state_d = sIdle;
            end
        endcase
    end

    // Response fields, synchronous read and completion counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q       <= '0;
            resp_data   <= '0;
            resp_id     <= '0;
            resp_wen    <= 1'b0;
            resp_err    <= 1'b0;
            read_count  <= '0;
            write_count <= '0;
        end else begin
            if (pop) begin
                idx_q     <= head_idx;
                resp_id   <= head.id;
                resp_wen  <= head.wen;
                resp_err  <= !head_ok;
                resp_data <= (head.wen && head_ok) ? head.data : '0;
            end
            if (state == sRead) begin
                resp_data <= mem[idx_q];
            end
            if (resp_fire) begin
                if (resp_wen) begin
                    write_count <= write_count + 32'd1;
                end else begin
                    read_count <= read_count + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ring_mem_server.sv
// tb_ring_mem_server: scoreboard bench for ring_mem_server.
// Reference model is a plain word array updated in request order.
module tb_ring_mem_server;

    localparam int DEPTH = 256;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_address = '0;
    logic [31:0] req_data = '0;
    logic        req_wen = 1'b0;
    logic [7:0]  req_id = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic [7:0]  resp_id;
    logic        resp_wen;
    logic        resp_err;
    logic        init_wen = 1'b0;
    logic [7:0]  init_addr = '0;
    logic [31:0] init_data = '0;
    logic [31:0] read_count;
    logic [31:0] write_count;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  id;
        logic        wen;
        logic        err;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] model [DEPTH];
    logic [31:0] rd_m = '0;
    logic [31:0] wr_m = '0;
    int          n_vec = 0;
    int          n_fail = 0;
    int          rr_mode = 1;

    always #5 clock = ~clock;

    ring_mem_server #(
        .DEPTH      (DEPTH),
        .FIFO_DEPTH (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_address (req_address),
        .req_data    (req_data),
        .req_wen     (req_wen),
        .req_id      (req_id),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_id     (resp_id),
        .resp_wen    (resp_wen),
        .resp_err    (resp_err),
        .init_wen    (init_wen),
        .init_addr   (init_addr),
        .init_data   (init_data),
        .read_count  (read_count),
        .write_count (write_count)
    );

    function automatic void chk(string n, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", n, act, exp);
        end
    endfunction

    // Consumer side: 0 = stalled, 1 = always ready, 2 = random.
    always @(posedge clock) begin
        #1;
        case (rr_mode)
            0:       resp_ready = 1'b0;
            1:       resp_ready = 1'b1;
            default: resp_ready = ($urandom_range(9) < 7);
        endcase
    end

    // Monitor: every response handshake is checked against the queue head.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", {56'd0, resp_id}, 64'hFFFF);
            end else begin
                e = exp_q.pop_front();
                chk("resp_data", resp_data, e.data);
                chk("resp_tag", {resp_err, resp_wen, resp_id},
                    {e.err, e.wen, e.id});
                if (e.wen) wr_m = wr_m + 1;
                else       rd_m = rd_m + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_init(input logic [7:0] a, input logic [31:0] d);
        init_addr = a;
        init_data = d;
        init_wen  = 1'b1;
        tick();
        init_wen  = 1'b0;
        model[a]  = d;
    endtask

    // Drives one request until accepted; returns just after the accept edge.
    task automatic send(input logic [31:0] a, input logic [31:0] d,
                        input logic w, input logic [7:0] id);
        int   t;
        exp_t e;
        logic [31:0] idx;
        req_valid   = 1'b1;
        req_address = a;
        req_data    = d;
        req_wen     = w;
        req_id      = id;
        t = 0;
        forever begin
            @(negedge clock);
            if (req_ready) break;
            t++;
            if (t > 500) begin
                n_vec++;
                n_fail++;
                $display("FAIL req_accept_timeout: id %0h never accepted", id);
                break;
            end
        end
        if (t <= 500) begin
            idx   = a >> 2;
            e.id  = id;
            e.wen = w;
            e.err = (idx >= DEPTH);
            if (e.err)  e.data = '0;
            else if (w) begin
                e.data     = d;
                model[idx] = d;
            end else    e.data = model[idx];
            exp_q.push_back(e);
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic lat_from(input int start, output int e);
        e = start;
        while (!resp_valid && e < 50) begin
            tick();
            e++;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge clock);
            t++;
        end
        tick();
        chk("drain_left", exp_q.size(), 0);
        chk("read_count", read_count, rd_m);
        chk("write_count", write_count, wr_m);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        tick();
        chk("ready_in_reset", req_ready, 0);
        chk("valid_in_reset", resp_valid, 0);
        reset = 1'b0;
        rd_m  = '0;
        wr_m  = '0;
        #1;
        chk("ready_after_reset", req_ready, 1);
        chk("rst_resp", {resp_valid, resp_err, resp_wen, resp_id, resp_data}, 0);
        chk("rst_counts", {read_count, write_count}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          e;
        logic [31:0] a;
        logic [31:0] d;

        tick();
        do_reset();

        for (int i = 0; i < DEPTH; i++) begin
            do_init(8'(i), $urandom);
        end

        // Preload then read back through the ring.
        do_init(8'h10, 32'h2063FFFF);
        send(32'h40, 32'h0, 1'b0, 8'h07);
        lat_from(1, e);
        chk("lat_read", e, 3);
        drain();

        // Write echoes data, following read sees it.
        send(32'h8, 32'hDEADBEEF, 1'b1, 8'h11);
        lat_from(1, e);
        chk("lat_write", e, 2);
        send(32'h8, 32'h0, 1'b0, 8'h12);
        drain();

        // Out of range read.
        send(32'h400, 32'h0, 1'b0, 8'h33);
        lat_from(1, e);
        chk("lat_err", e, 2);
        drain();

        // Backpressure: one in flight plus a full queue.
        rr_mode = 0;
        for (int i = 0; i < 5; i++) begin
            send(32'(i * 4 + 100), 32'h0, 1'b0, 8'(8'hA0 + i));
        end
        chk("ready_when_full", req_ready, 0);
        chk("valid_when_stalled", resp_valid, 1);
        rr_mode = 1;
        drain();

        // Preload colliding with a pending write pop.
        send(32'h80, 32'hCAFE0001, 1'b1, 8'h42);
        init_addr = 8'd50;
        init_data = 32'h5A5A1234;
        init_wen  = 1'b1;
        tick();
        init_wen  = 1'b0;
        model[50] = 32'h5A5A1234;
        lat_from(2, e);
        chk("lat_init_stall", e, 3);
        send(32'h80, 32'h0, 1'b0, 8'h43);
        send(32'd200, 32'h0, 1'b0, 8'h44);
        drain();

        // Reset while a read sits in sRead.
        send(32'h20, 32'h13572468, 1'b1, 8'h50);
        drain();
        send(32'h20, 32'h0, 1'b0, 8'h51);
        tick();
        do_reset();
        repeat (5) tick();
        chk("no_resp_after_flush", resp_valid, 0);
        send(32'h20, 32'h0, 1'b0, 8'h52);
        drain();

        // Randomised traffic with random consumer stalls.
        rr_mode = 2;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(9))
                0:       a = $urandom;
                1:       a = 32'($urandom_range(DEPTH * 4 - 1, DEPTH)) << 2;
                default: a = (32'($urandom_range(DEPTH - 1)) << 2)
                             | 32'($urandom_range(3));
            endcase
            d = $urandom;
            if ($urandom_range(3) == 0) tick();
            send(a, d, 1'($urandom_range(1)), 8'($urandom));
            if (i % 50 == 49) begin
                drain();
                do_init(8'($urandom), $urandom);
                do_init(8'($urandom), $urandom);
            end
        end
        rr_mode = 1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
